// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto one register-file write port.
// Optional load extraction/extension is enabled with `define WB_LOAD_EXT_EN.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     aluValid_i,
  input  logic [4:0]               aluRd_i,
  input  logic [31:0]              aluVal_i,
  output logic                     stall_o,
  input  logic                     ldValid_i,
  output logic                     ldReady_o,
  input  logic [4:0]               ldRd_i,
  input  logic [31:0]              ldData_i,
  input  logic [2:0]               ldFunct3_i,
  input  logic [1:0]               ldAddrLo_i,
  output logic [4:0]               rdNum_o,
  output logic [31:0]              rdVal_o,
  output logic                     regWrite_o,
  output logic [$clog2(DEPTH):0]   pendCnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_LIMIT);

  logic [4:0]    rd_mem_q  [DEPTH];
  logic [31:0]   val_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] age_q, age_d;
  logic          stall_q, stall_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    rd_num_q, rd_num_d;
  logic [31:0]   rd_val_q, rd_val_d;
  logic          push, pop, empty, ld_acc, ld_write, alu_write;
  logic [31:0]   ld_ext;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    ld_byte = ldData_i[{ldAddrLo_i, 3'b000} +: 8];
    ld_half = ldAddrLo_i[1] ? ldData_i[31:16] : ldData_i[15:0];
    case (ldFunct3_i)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ldData_i;
    endcase
  end
`else
  logic unused_ext;
  assign unused_ext = ^{ldFunct3_i, ldAddrLo_i};
  assign ld_ext     = ldData_i;
`endif

  // Readiness depends only on registered occupancy, so a popping cycle cannot accept into a full FIFO.
  assign ldReady_o = rst_n && (cnt_q < FULL_CNT);

  always_comb begin
    empty     = (cnt_q == '0);
    ld_acc    = ldValid_i && ldReady_o;
    ld_write  = ld_acc && (ldRd_i != 5'd0);
    alu_write = aluValid_i && (aluRd_i != 5'd0);
    push      = 1'b0;
    pop       = 1'b0;
    wr_en_d   = 1'b0;
    rd_num_d  = '0;
    rd_val_d  = '0;
    if (stall_q && !empty) begin
      pop      = 1'b1;
      push     = ld_write;
      wr_en_d  = 1'b1;
      rd_num_d = rd_mem_q[rd_ptr_q];
      rd_val_d = val_mem_q[rd_ptr_q];
    end else if (alu_write) begin
      push     = ld_write;
      wr_en_d  = 1'b1;
      rd_num_d = aluRd_i;
      rd_val_d = aluVal_i;
    end else if (!empty) begin
      pop      = 1'b1;
      push     = ld_write;
      wr_en_d  = 1'b1;
      rd_num_d = rd_mem_q[rd_ptr_q];
      rd_val_d = val_mem_q[rd_ptr_q];
    end else if (ld_write) begin
      wr_en_d  = 1'b1;
      rd_num_d = ldRd_i;
      rd_val_d = ld_ext;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Age saturates at the limit; the stall lasts one cycle because that cycle always pops.
    if (pop || empty)          age_d = '0;
    else if (age_q != AGE_MAX) age_d = age_q + AW'(1);
    else                       age_d = age_q;
    stall_d = !stall_q && (age_q == AGE_MAX) && !pop && !empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_num_q <= '0;
      rd_val_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
      wr_en_q  <= wr_en_d;
      rd_num_q <= rd_num_d;
      rd_val_q <= rd_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]  <= ldRd_i;
      val_mem_q[wr_ptr_q] <= ld_ext;
    end
  end

  assign stall_o    = stall_q;
  assign regWrite_o = wr_en_q;
  assign rdNum_o    = rd_num_q;
  assign rdVal_o    = rd_val_q;
  assign pendCnt_o  = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-level reference model feeding a scoreboard of expected writes.
// Honours `define WB_LOAD_EXT_EN for the load extension model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_LOAD_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_val = '0;
  logic        stall;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [2:0]  ld_f3 = '0;
  logic [1:0]  ld_lo = '0;
  logic [4:0]  rd_num;
  logic [31:0] rd_val;
  logic        reg_write;
  logic [$clog2(DEPTH):0] pend_cnt;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid_i(alu_valid), .aluRd_i(alu_rd), .aluVal_i(alu_val),
    .stall_o(stall),
    .ldValid_i(ld_valid), .ldReady_o(ld_ready), .ldRd_i(ld_rd),
    .ldData_i(ld_data), .ldFunct3_i(ld_f3), .ldAddrLo_i(ld_lo),
    .rdNum_o(rd_num), .rdVal_o(rd_val), .regWrite_o(reg_write),
    .pendCnt_o(pend_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mq[$];
  int          m_age = 0;
  bit          m_stall = 1'b0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] lo);
    int unsigned b, h;
    logic [31:0] e;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    e = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    e = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    e = b;
      3'd5:    e = h;
      default: e = d;
    endcase
    return EXT_EN ? e : d;
  endfunction

  // One cycle: check model-predicted status, drive inputs, advance the model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] aval,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] lo, output bit acc);
    int sz;
    bit popped, bypass, ldw, nstall;
    logic [36:0] lw;
    @(posedge clk); #1;
    sz = mq.size();
    check("pend_cnt", 32'(pend_cnt), 32'(sz));
    check("ld_ready", 32'(ld_ready), 32'(sz < DEPTH));
    check("stall", 32'(stall), 32'(m_stall));
    alu_valid = av; alu_rd = ar; alu_val = aval;
    ld_valid = lv; ld_rd = lr; ld_data = ld; ld_f3 = f3; ld_lo = lo;
    acc = lv && (sz < DEPTH);
    ldw = acc && (lr != 5'd0);
    lw = {lr, ref_ext(ld, f3, lo)};
    popped = 1'b0;
    bypass = 1'b0;
    if (m_stall && sz > 0) begin
      exp_q.push_back(mq.pop_front()); popped = 1'b1;
    end else if (av && ar != 5'd0) begin
      exp_q.push_back({ar, aval});
    end else if (sz > 0) begin
      exp_q.push_back(mq.pop_front()); popped = 1'b1;
    end else if (ldw) begin
      exp_q.push_back(lw); bypass = 1'b1;
    end
    if (ldw && !bypass) mq.push_back(lw);
    nstall = !m_stall && (m_age >= LIMIT) && !popped && (sz > 0);
    m_age = (popped || sz == 0) ? 0 : m_age + 1;
    m_stall = nstall;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
    end
    check("rst_stall", 32'(stall), 32'd0);
    exp_q.delete();
    mq.delete();
    m_age = 0;
    m_stall = 1'b0;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && reg_write) begin
      logic [36:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got x%0d=%0h, expected no write", rd_num, rd_val);
      end else begin
        e = exp_q.pop_front();
        if ({rd_num, rd_val} !== e) begin
          fails++;
          $display("FAIL write: got x%0d=%0h, expected x%0d=%0h", rd_num, rd_val, e[36:32], e[31:0]);
        end
      end
      last_rd = rd_num;
      last_val = rd_val;
    end
  end

  initial begin
    bit acc;
    int ld_idx;
    logic [4:0] lds[3];
    logic        r_av, r_lv;
    logic [4:0]  r_ar, r_lr;
    logic [31:0] r_aval, r_ld;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    bit          ld_hold;
    int          alu_pct;

    do_reset();
    idle(1);

    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, acc);
    idle(2);
    check("alu_only_rd", 32'(last_rd), 32'd5);
    check("alu_only_val", last_val, 32'h1234);

    step(1, 3, 32'hA, 1, 7, 32'hB, 3'd2, 0, acc);
    idle(3);
    check("collision_last_rd", 32'(last_rd), 32'd7);
    check("collision_last_val", last_val, 32'hB);

    lds[0] = 5'd8; lds[1] = 5'd9; lds[2] = 5'd10;
    ld_idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(1, 1, 32'(100 + c), ld_idx < 3, lds[ld_idx % 3], 32'(200 + ld_idx), 3'd2, 0, acc);
      if (acc) ld_idx++;
    end
    idle(4);
    check("starve_all_loads_accepted", 32'(ld_idx), 32'd3);
    check("starve_last_rd", 32'(last_rd), 32'd10);

    step(0, 0, 0, 1, 0, 32'hDEAD, 3'd2, 0, acc);
    step(0, 0, 0, 1, 4, 32'h0000_80FF, 3'd0, 2'd1, acc);
    idle(2);
    check("lb_rd", 32'(last_rd), 32'd4);
    check("lb_val", last_val, EXT_EN ? 32'hFFFF_FF80 : 32'h0000_80FF);

    ld_hold = 1'b0;
    r_av = 0; r_ar = 0; r_aval = 0; r_lv = 0; r_lr = 0; r_ld = 0; r_f3 = 0; r_lo = 0;
    for (int i = 0; i < 600; i++) begin
      alu_pct = (i < 200) ? 90 : (i < 400) ? 50 : 10;
      if (i == 300) begin
        do_reset();
        ld_hold = 1'b0;
      end
      if (!m_stall) begin
        r_av = ($urandom_range(0, 99) < alu_pct);
        r_ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r_aval = $urandom;
      end
      if (!ld_hold) begin
        r_lv = ($urandom_range(0, 99) < 60);
        r_lr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r_ld = $urandom;
        r_f3 = 3'($urandom_range(0, 7));
        r_lo = 2'($urandom_range(0, 3));
      end
      step(r_av, r_ar, r_aval, r_lv, r_lr, r_ld, r_f3, r_lo, acc);
      ld_hold = r_lv && !acc;
    end
    idle(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
